// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared types and constants for the DIV/IDIV sequencer.
// Holds state encodings, operand widths and quotient limits.
package alu_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

    localparam int W_BYTE = 8;
    localparam int W_WORD = 16;

    localparam logic [3:0] CNT_BYTE = 4'(W_BYTE - 1);
    localparam logic [3:0] CNT_WORD = 4'(W_WORD - 1);

    localparam logic [15:0] QMAX_BYTE = 16'h007F;
    localparam logic [15:0] QMAX_WORD = 16'h7FFF;
    localparam logic [15:0] QMIN_BYTE = 16'h0080;
    localparam logic [15:0] QMIN_WORD = 16'h8000;

endpackage

// File: rtl/alu_divstep.sv
// alu_divstep: one restoring shift-subtract step.
// Shifts din into the partial remainder and trial-subtracts the divisor.
module alu_divstep (
    input  logic [16:0] prem,
    input  logic        din,
    input  logic [15:0] dvs,
    output logic [16:0] prem_nx,
    output logic        qbit
);

    logic [16:0] sh;
    logic [17:0] diff;

    // A set prem[16] means the shifted value already exceeds any divisor.
    always_comb begin
        sh      = {prem[15:0], din};
        diff    = {1'b0, sh} - {2'b00, dvs};
        qbit    = prem[16] | ~diff[17];
        prem_nx = qbit ? diff[16:0] : sh;
    end

endmodule

// File: rtl/alu_divseq.sv
// alu_divseq: multi-cycle DIV/IDIV sequencer beside the ALU.
// Result packs quotient low, remainder high, like the multiplier.
module alu_divseq
    import alu_div_pkg::*;
#(
    parameter bit NEG_MIN_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [15:0] y,
    input  logic        word_op,
    input  logic        signed_op,
    output logic        busy,
    output logic        done,
    output logic        div_err,
    output logic [31:0] o
);

    div_state_t state, state_nx;

    logic [31:0] xr;
    logic [15:0] yr;
    logic        wop, sop;
    logic [16:0] prem;
    logic [15:0] qsh, dvs;
    logic [3:0]  cnt;
    logic        qneg, rneg;

    logic        xs, ys;
    logic [31:0] dmag;
    logic [15:0] vmag, hi, lo;
    logic        prep_err;

    logic [16:0] step_prem;
    logic        step_q;

    logic [15:0] q, r, quo, rem, qmax, qmin;
    logic        min_ok, fix_err;
    logic [31:0] res;

    // Operand magnitudes and early overflow / divide-by-zero detection.
    always_comb begin
        xs = sop & (wop ? xr[31] : xr[15]);
        ys = sop & (wop ? yr[15] : yr[7]);
        if (wop) begin
            dmag = xs ? (~xr + 32'd1) : xr;
            vmag = ys ? (~yr + 16'd1) : yr;
            hi   = dmag[31:16];
            lo   = dmag[15:0];
        end else begin
            dmag = {16'h0, xs ? (~xr[15:0] + 16'd1) : xr[15:0]};
            vmag = {8'h0, ys ? (~yr[7:0] + 8'd1) : yr[7:0]};
            hi   = {8'h0, dmag[15:8]};
            lo   = {dmag[7:0], 8'h0};
        end
        prep_err = (vmag == 16'h0) | (hi >= vmag);
    end

    alu_divstep u_step (
        .prem    (prem),
        .din     (qsh[15]),
        .dvs     (dvs),
        .prem_nx (step_prem),
        .qbit    (step_q)
    );

    // Sign fix-up and signed quotient range check.
    always_comb begin
        q      = wop ? qsh : {8'h0, qsh[7:0]};
        r      = wop ? prem[15:0] : {8'h0, prem[7:0]};
        quo    = qneg ? (~q + 16'd1) : q;
        rem    = rneg ? (~r + 16'd1) : r;
        qmax   = wop ? QMAX_WORD : QMAX_BYTE;
        qmin   = wop ? QMIN_WORD : QMIN_BYTE;
        min_ok = !NEG_MIN_ERR && qneg && (q == qmin);
        fix_err = sop && (q > qmax) && !min_ok;
        res    = wop ? {rem, quo} : {16'h0, rem[7:0], quo[7:0]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nx = S_PREP;
            S_PREP: begin
                busy     = 1'b1;
                state_nx = prep_err ? S_DONE : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt == 4'd0) state_nx = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr      <= '0;
            yr      <= '0;
            wop     <= 1'b0;
            sop     <= 1'b0;
            prem    <= '0;
            qsh     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            o       <= '0;
            div_err <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        xr  <= x;
                        yr  <= y;
                        wop <= word_op;
                        sop <= signed_op;
                    end
                end
                S_PREP: begin
                    qneg <= xs ^ ys;
                    rneg <= xs;
                    dvs  <= vmag;
                    prem <= {1'b0, hi};
                    qsh  <= lo;
                    cnt  <= wop ? CNT_WORD : CNT_BYTE;
                    if (prep_err) begin
                        o       <= '0;
                        div_err <= 1'b1;
                    end
                end
                S_ITER: begin
                    prem <= step_prem;
                    qsh  <= {qsh[14:0], step_q};
                    cnt  <= cnt - 4'd1;
                end
                S_FIX: begin
                    if (fix_err) begin
                        o       <= '0;
                        div_err <= 1'b1;
                    end else begin
                        o       <= res;
                        div_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divseq.sv
// tb_alu_divseq: scoreboard bench for alu_divseq.
// u0 raises #DE on a most-negative quotient, u1 allows it.
module tb_alu_divseq;

    // Edges from accept edge k to the edge after which done is visible;
    // done is then high in cycle k+lat+1 (k+19 word, k+11 byte, k+2 early error).
    localparam int LAT_W = 18;
    localparam int LAT_B = 10;
    localparam int LAT_E = 1;

    typedef struct {
        logic [31:0] o0;
        logic        e0;
        logic [31:0] o1;
        logic        e1;
        int          lat;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x = '0;
    logic [15:0] y = '0;
    logic        word_op = 1'b0;
    logic        signed_op = 1'b0;

    logic        u0_busy, u0_done, u0_err;
    logic [31:0] u0_o;
    logic        u1_busy, u1_done, u1_err;
    logic [31:0] u1_o;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    exp_t exp_q[$];

    alu_divseq #(.NEG_MIN_ERR(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .word_op(word_op), .signed_op(signed_op),
        .busy(u0_busy), .done(u0_done), .div_err(u0_err), .o(u0_o)
    );

    alu_divseq #(.NEG_MIN_ERR(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .word_op(word_op), .signed_op(signed_op),
        .busy(u1_busy), .done(u1_done), .div_err(u1_err), .o(u1_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && (u0_done || u1_done)) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {30'h0, u1_done, u0_done}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("u0_done", {31'h0, u0_done}, 32'h1);
                chk("u1_done", {31'h0, u1_done}, 32'h1);
                chk("latency", cyc - e.k, e.lat);
                chk("u0_o", u0_o, e.o0);
                chk("u0_err", {31'h0, u0_err}, {31'h0, e.e0});
                chk("u1_o", u1_o, e.o1);
                chk("u1_err", {31'h0, u1_err}, {31'h0, e.e1});
            end
        end
    end

    task automatic push(input logic [31:0] o0, input logic e0,
                        input logic [31:0] o1, input logic e1,
                        input int lat, input int k);
        exp_t e;
        e.o0 = o0; e.e0 = e0; e.o1 = o1; e.e1 = e1;
        e.lat = lat; e.k = k;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] xv, input logic [15:0] yv,
                         input logic w, input logic s,
                         input logic [31:0] o0, input logic e0,
                         input logic [31:0] o1, input logic e1,
                         input int lat);
        @(negedge clk);
        x = xv; y = yv; word_op = w; signed_op = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push(o0, e0, o1, e1, lat, cyc);
        x = $urandom;
        y = 16'($urandom);
        word_op = 1'($urandom);
        signed_op = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("done_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kd;
        bit seen;
        #17;
        chk("rst_busy", {31'h0, u0_busy}, 32'h0);
        chk("rst_done", {31'h0, u0_done}, 32'h0);
        chk("rst_err", {31'h0, u0_err}, 32'h0);
        chk("rst_o", u0_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned word 65541 / 3, with busy window check.
        issue(32'h0001_0005, 16'h0003, 1, 0,
              32'h0000_5557, 0, 32'h0000_5557, 0, LAT_W);
        for (int j = 0; j < LAT_W; j++) begin
            @(negedge clk);
            chk("busy_window", {31'h0, u0_busy}, 32'h1);
        end
        wait_idle();

        // Byte divides; upper x and y bits must be ignored.
        issue(32'h0000_0064, 16'h0007, 0, 0,
              32'h0000_020E, 0, 32'h0000_020E, 0, LAT_B);
        wait_idle();
        issue(32'hABCD_0064, 16'hFF07, 0, 0,
              32'h0000_020E, 0, 32'h0000_020E, 0, LAT_B);
        wait_idle();
        issue(32'h0000_FF9C, 16'h0007, 0, 1,
              32'h0000_FEF2, 0, 32'h0000_FEF2, 0, LAT_B);
        wait_idle();
        issue(32'h0000_0064, 16'h00F9, 0, 1,
              32'h0000_02F2, 0, 32'h0000_02F2, 0, LAT_B);
        wait_idle();

        // Word arithmetic.
        issue(32'h0002_FFFF, 16'h0010, 1, 0,
              32'h000F_2FFF, 0, 32'h000F_2FFF, 0, LAT_W);
        wait_idle();
        issue(32'hFFFF_FFF9, 16'h0002, 1, 1,
              32'hFFFF_FFFD, 0, 32'hFFFF_FFFD, 0, LAT_W);
        wait_idle();

        // Early errors.
        issue(32'h0001_2345, 16'h0000, 1, 0,
              32'h0, 1, 32'h0, 1, LAT_E);
        wait_idle();
        issue(32'h0000_0064, 16'h0007, 0, 0,
              32'h0000_020E, 0, 32'h0000_020E, 0, LAT_B);
        wait_idle();
        issue(32'h0003_0000, 16'h0003, 1, 0,
              32'h0, 1, 32'h0, 1, LAT_E);
        wait_idle();
        issue(32'h0000_0064, 16'h0100, 0, 0,
              32'h0, 1, 32'h0, 1, LAT_E);
        wait_idle();
        issue(32'h0000_FF00, 16'h0001, 0, 1,
              32'h0, 1, 32'h0, 1, LAT_E);
        wait_idle();

        // Late overflow and most-negative quotient.
        issue(32'h0000_FF80, 16'h0001, 0, 1,
              32'h0, 1, 32'h0000_0080, 0, LAT_B);
        wait_idle();
        issue(32'hFFFF_8000, 16'h0001, 1, 1,
              32'h0, 1, 32'h0000_8000, 0, LAT_W);
        wait_idle();
        issue(32'h0000_8000, 16'h0001, 1, 1,
              32'h0, 1, 32'h0, 1, LAT_W);
        wait_idle();

        // start held high throughout: one done, then accept after DONE.
        @(negedge clk);
        x = 32'h0001_0005; y = 16'h0003; word_op = 1; signed_op = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        push(32'h0000_5557, 0, 32'h0000_5557, 0, LAT_W, cyc);
        seen = 1'b0;
        kd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u0_done) begin
                seen = 1'b1;
                kd = cyc;
                break;
            end
        end
        chk("hold_done_seen", {31'h0, seen}, 32'h1);
        x = 32'h0000_0064; y = 16'h0007; word_op = 0; signed_op = 0;
        push(32'h0000_020E, 0, 32'h0000_020E, 0, LAT_B, kd + 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of ITER.
        issue(32'h0001_0005, 16'h0003, 1, 0,
              32'h0000_5557, 0, 32'h0000_5557, 0, LAT_W);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("abort_busy", {31'h0, u0_busy}, 32'h0);
        chk("abort_done", {31'h0, u0_done}, 32'h0);
        chk("abort_o", u0_o, 32'h0);
        chk("abort_err", {31'h0, u0_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(32'h0000_FF9C, 16'h0007, 0, 1,
              32'h0000_FEF2, 0, 32'h0000_FEF2, 0, LAT_B);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_divseq.md
Name: alu_divseq

Overview:
- Multi-cycle sequencer for DIV/IDIV. The ALU's muldiv path only multiplies; this block supplies division.
- Performs restoring division, one quotient bit per cycle, in byte or word mode.
- Packs results the same way the multiplier does: quotient in the low half, remainder in the high half.
- Sits beside the ALU. The microcode sequencer stalls on busy and writes back on done.

Parameters:
- NEG_MIN_ERR, 1: 1 = a quotient equal to the most negative value (0x80 / 0x8000) raises div_err (8086 behaviour); 0 = that quotient is allowed (80186 behaviour).

Ports:
- clk, input, 1: clock
- rst_n, input, 1: asynchronous active-low reset
- start, input, 1: request a division; sampled only in IDLE
- x, input, 32: dividend. Word mode: {DX,AX}. Byte mode: x[15:0] = AX.
- y, input, 16: divisor. Byte mode uses y[7:0].
- word_op, input, 1: 1 = 16-bit divide, 0 = 8-bit divide
- signed_op, input, 1: 1 = IDIV, 0 = DIV
- busy, output, 1: high from the cycle after start is accepted until done
- done, output, 1: one-cycle pulse; o and div_err are valid in this cycle
- div_err, output, 1: divide by zero or quotient overflow (#DE)
- o, output, 32: result. Word mode: {rem[15:0], quo[15:0]}. Byte mode: {16'h0, rem[7:0], quo[7:0]}.

Behaviour:
- Reset values: busy=0, done=0, div_err=0, o=0, state IDLE.
- Reset asserted mid-operation aborts immediately to IDLE with these values.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start=1 latches x, y, word_op and signed_op → PREP.
  - Inputs may change after the accept edge without effect.
- PREP (1 cycle):
  - If signed_op, take magnitudes of dividend (2W bits) and divisor (W bits), with W = 8 or 16. Record qneg = sign(dividend) ^ sign(divisor) and rneg = sign(dividend).
  - Divisor magnitude = 0 → DONE with div_err=1, o=0.
  - High W bits of the dividend magnitude ≥ divisor magnitude → DONE with div_err=1, o=0 (quotient ≥ 2^W).
  - Otherwise load the partial remainder with the high half, load the quotient shifter with the low half, set iteration counter = W-1 → ITER.
- ITER (W cycles):
  - Shift {prem, qsh} left by 1.
  - Trial-subtract the divisor from the (W+1)-bit partial remainder.
  - If non-negative, keep the difference and set qbit=1; else restore and set qbit=0.
  - Counter decrements; when the counter = 0 → FIX.
- FIX (1 cycle):
  - Apply signs: quo = qneg ? -q : q; rem = rneg ? -r : r.
  - If signed_op and magnitude q > 2^(W-1)-1 → div_err=1, o=0.
  - Exception: magnitude q = 2^(W-1) with qneg=1 and NEG_MIN_ERR=0 is not an error.
  - Otherwise register o → DONE.
- DONE (1 cycle): done=1, busy=0 → IDLE.
  - start is not accepted in DONE; it is accepted the next cycle.
- Latency, counting the start accept edge as k:
  - done is high in cycle k+3+W: word k+19, byte k+11.
  - PREP error: done in cycle k+2.
- Holding and ignoring rules:
  - o and div_err hold their values until the next done. On a non-error done, div_err is cleared.
  - start while busy is ignored; there is no queueing.
  - The remainder always takes the sign of the dividend. The quotient truncates toward zero.

Decomposition:
- Shared package alu_div_pkg holds:
  - state encodings (IDLE=0, PREP=1, ITER=2, FIX=3, DONE=4)
  - W_BYTE=8, W_WORD=16
  - the overflow limit constants
- One sub-module, alu_divstep: a combinational single shift-subtract step.
  - Inputs: prem (17 bits), next dividend bit, divisor (16 bits).
  - Outputs: new prem, qbit.
  - Byte mode zero-extends the divisor.
- The FSM, counter and sign fix-up stay in alu_divseq.

Test Plan:
- Unsigned word divide:
  - Stimulus: x=0x00010005, y=0x0003, word_op=1.
  - Required: done at k+19, o=0x00005557, div_err=0, busy high k+1..k+18.
- Unsigned byte divide:
  - Stimulus: x=0x0064, y=0x07, word_op=0.
  - Required: done at k+11, o[15:0]=0x020E.
- Signed byte divide:
  - Stimulus: x=0xFF9C (-100), y=0x07, signed_op=1.
  - Required: o[15:0]=0xFEF2 (quo -14, rem -2).
  - Also x=0x0064, y=0xF9 → o[15:0]=0x02F2.
- Errors:
  - Word y=0 → done at k+2, div_err=1, o=0.
  - Unsigned word x=0x00030000, y=0x0003 → div_err at k+2.
  - Signed byte x=0xFF80, y=0x01: with NEG_MIN_ERR=1 → div_err at k+11; with NEG_MIN_ERR=0 → o[15:0]=0x0080, div_err=0.
- Handshake:
  - start pulsed every cycle during a word divide → exactly one done. A following start in the cycle after done is accepted.
  - Changing x/y after the accept edge does not alter the result.
- Reset mid-ITER:
  - Drop rst_n asynchronously at k+8 → busy, done and o go to 0 before the next edge.
  - No done pulse follows. A new divide after reset completes correctly.
